// File: rtl/intpol2_run_sequencer_if.sv
// Run request channel between host registers and the run sequencer.
// Host drives the request fields; the sequencer answers with req_ready.
interface intpol2_run_sequencer_if #(
  parameter int CONFIG_WIDTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BLK_CNT_W    = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_bypass;
  logic [DATA_WIDTH-1:0]   req_ix;
  logic [DATA_WIDTH-1:0]   req_ix2;
  logic [CONFIG_WIDTH-1:0] req_len;
  logic [BLK_CNT_W-1:0]    req_nblk;

  modport master (
    output req_valid,
    output req_bypass,
    output req_ix,
    output req_ix2,
    output req_len,
    output req_nblk,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_bypass,
    input  req_ix,
    input  req_ix2,
    input  req_len,
    input  req_nblk,
    output req_ready
  );
endinterface

// File: rtl/intpol2_run_sequencer.sv
// Run-level scheduler for intpol2_D4_IQ_CORE: holds config, pulses
// start once per block, watches done/busy/stall and aborts on timeout.
module intpol2_run_sequencer #(
  parameter int CONFIG_WIDTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BLK_CNT_W    = 16,
  parameter int STALL_CNT_W  = 32,
  parameter int TIMEOUT      = 1024
) (
  input  logic                      clk,
  input  logic                      rstn,
  intpol2_run_sequencer_if.slave    rq,
  input  logic                      abort,
  input  logic [7:0]                core_status,
  output logic                      core_start,
  output logic [4*CONFIG_WIDTH-1:0] core_config_reg,
  output logic                      busy,
  output logic                      run_done,
  output logic                      run_err,
  output logic [1:0]                err_code,
  output logic [BLK_CNT_W-1:0]      blk_count,
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WACK,
    S_RUN,
    S_GAP,
    S_FIN,
    S_ERR
  } state_t;

  state_t               state;
  state_t               nxt;
  logic [1:0]           err_nxt;
  logic [WD_W-1:0]      wd;
  logic [BLK_CNT_W-1:0] nblk_q;
  logic                 armed;
  logic                 ready_c;

  logic st_done;
  logic st_busy;
  logic st_stall;
  logic accept;
  logic wd_max;
  logic kill;

  assign st_done  = core_status[0];
  assign st_busy  = core_status[1];
  assign st_stall = core_status[2] | core_status[3];
  assign accept   = rq.req_valid & ready_c;
  assign wd_max   = (wd == WD_W'(TIMEOUT - 1));
  assign rq.req_ready = ready_c;

  // Terminal states finish on their own; abort only cuts live run states.
  assign kill = abort & (state inside {
    S_LOAD, S_START, S_WACK, S_RUN, S_GAP});

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next state; abort overrides, watchdog only fires on non-done cycles.
  always_comb begin
    nxt     = state;
    err_nxt = 2'd0;
    unique case (state)
      S_IDLE: begin
        if (accept)
          nxt = (rq.req_nblk == '0) ? S_FIN : S_LOAD;
      end
      S_LOAD:  nxt = S_START;
      S_START: nxt = S_WACK;
      S_WACK: begin
        if (st_done | st_busy) begin
          nxt = S_RUN;
        end else if (wd_max) begin
          nxt     = S_ERR;
          err_nxt = 2'd1;
        end
      end
      S_RUN: begin
        if (st_done) begin
          nxt = S_GAP;
        end else if (st_stall && wd_max) begin
          nxt     = S_ERR;
          err_nxt = 2'd2;
        end
      end
      S_GAP: begin
        if (!st_done && !st_busy)
          nxt = (blk_count == nblk_q) ? S_FIN : S_START;
      end
      S_FIN:   nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (kill) begin
      nxt     = S_ERR;
      err_nxt = 2'd3;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    ready_c    = armed & (state == S_IDLE);
    core_start = (state == S_START) & ~abort;
    busy       = (state != S_IDLE);
    run_done   = (state == S_FIN);
    run_err    = (state == S_ERR);
  end

  // Holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) armed <= 1'b0;
    else       armed <= 1'b1;
  end

  // Config word and block target, captured on accept and held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_config_reg <= '0;
      nblk_q          <= '0;
    end else if (accept) begin
      core_config_reg <= {
        rq.req_len,
        CONFIG_WIDTH'(rq.req_ix2),
        CONFIG_WIDTH'(rq.req_ix),
        {(CONFIG_WIDTH-1){1'b0}},
        rq.req_bypass};
      nblk_q <= rq.req_nblk;
    end
  end

  // Watchdog: WAIT_ACK cycles or consecutive RUN stall cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      wd <= '0;
    else if (nxt != state)
      wd <= '0;
    else if (state == S_WACK || (state == S_RUN && st_stall))
      wd <= wd + WD_W'(1);
    else
      wd <= '0;
  end

  // Run counters and the sticky error code.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_count <= '0;
      stall_cnt <= '0;
      err_code  <= 2'd0;
    end else if (accept) begin
      blk_count <= '0;
      stall_cnt <= '0;
      err_code  <= 2'd0;
    end else begin
      if (state == S_RUN && st_done && !kill)
        blk_count <= blk_count + BLK_CNT_W'(1);
      if (state == S_RUN && st_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (nxt == S_ERR)
        err_code <= err_nxt;
    end
  end

endmodule

// File: tb/tb_intpol2_run_sequencer.sv
// Directed bench for intpol2_run_sequencer with hand-derived
// cycle timing for accept, start, watchdog and abort cases.
module tb_intpol2_run_sequencer;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   core_status = 8'h00;
  logic         core_start;
  logic [127:0] core_config_reg;
  logic         busy;
  logic         run_done;
  logic         run_err;
  logic [1:0]   err_code;
  logic [15:0]  blk_count;
  logic [31:0]  stall_cnt;

  int nchk = 0;
  int nfail = 0;
  int n_start = 0;
  int n_done = 0;
  int n_err = 0;
  int n_viol = 0;

  intpol2_run_sequencer_if #(
    .CONFIG_WIDTH(32), .DATA_WIDTH(32), .BLK_CNT_W(16)
  ) rq_if ();

  intpol2_run_sequencer #(
    .CONFIG_WIDTH(32), .DATA_WIDTH(32), .BLK_CNT_W(16),
    .STALL_CNT_W(32), .TIMEOUT(1024)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rq(rq_if),
    .abort(abort),
    .core_status(core_status),
    .core_start(core_start),
    .core_config_reg(core_config_reg),
    .busy(busy),
    .run_done(run_done),
    .run_err(run_err),
    .err_code(err_code),
    .blk_count(blk_count),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (core_start) begin
        n_start++;
        if (core_status[1:0] != 2'b00) n_viol++;
      end
      if (run_done) n_done++;
      if (run_err)  n_err++;
    end
  endtask

  task automatic zero_cnt();
    n_start = 0;
    n_done  = 0;
    n_err   = 0;
    n_viol  = 0;
  endtask

  task automatic accept(input logic byp,
                        input logic [31:0] ix,
                        input logic [31:0] ix2,
                        input logic [31:0] len,
                        input logic [15:0] nblk);
    chk("ready_before_accept", rq_if.req_ready, 1);
    rq_if.req_bypass = byp;
    rq_if.req_ix     = ix;
    rq_if.req_ix2    = ix2;
    rq_if.req_len    = len;
    rq_if.req_nblk   = nblk;
    rq_if.req_valid  = 1'b1;
    cyc(1);
    rq_if.req_valid  = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 50 && !core_start; i++) cyc(1);
    chk(tag, core_start, 1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 50 && !run_done; i++) cyc(1);
    chk(tag, run_done, 1);
  endtask

  initial begin
    int k;
    rq_if.req_valid  = 1'b0;
    rq_if.req_bypass = 1'b0;
    rq_if.req_ix     = '0;
    rq_if.req_ix2    = '0;
    rq_if.req_len    = '0;
    rq_if.req_nblk   = '0;

    // T1: reset with a busy core
    core_status = 8'h02;
    #23;
    chk("rst_ready", rq_if.req_ready, 0);
    chk("rst_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", run_done, 0);
    chk("rst_err", run_err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_blk", blk_count, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_cfg", core_config_reg, 0);
    rstn = 1'b1;
    core_status = 8'h00;
    cyc(2);
    chk("post_rst_ready", rq_if.req_ready, 1);
    chk("post_rst_cfg", core_config_reg, 0);

    // T2: single block, done 20 cycles after start
    zero_cnt();
    accept(1'b0, 32'h4000_0000, 32'h1000_0000, 32'd8, 16'd1);
    chk("t2_cfg", core_config_reg,
        {32'd8, 32'h1000_0000, 32'h4000_0000, 32'd0});
    chk("t2_load_start", core_start, 0);
    chk("t2_busy", busy, 1);
    chk("t2_ready_low", rq_if.req_ready, 0);
    cyc(1);
    chk("t2_start_t2", core_start, 1);
    core_status = 8'h02;
    cyc(19);
    chk("t2_run_busy", busy, 1);
    core_status = 8'h01;
    cyc(1);
    chk("t2_blk_gap", blk_count, 1);
    core_status = 8'h00;
    cyc(1);
    chk("t2_run_done", run_done, 1);
    cyc(5);
    chk("t2_n_start", n_start, 1);
    chk("t2_n_done", n_done, 1);
    chk("t2_n_err", n_err, 0);
    chk("t2_blk", blk_count, 1);
    chk("t2_code", err_code, 0);
    chk("t2_idle", busy, 0);
    chk("t2_cfg_held", core_config_reg,
        {32'd8, 32'h1000_0000, 32'h4000_0000, 32'd0});

    // T3: three blocks, done held 2 cycles, bypass set
    zero_cnt();
    accept(1'b1, 32'h11, 32'h121, 32'd16, 16'd3);
    chk("t3_cfg", core_config_reg,
        {32'd16, 32'h121, 32'h11, 32'd1});
    for (int b = 0; b < 3; b++) begin
      wait_start("t3_start");
      core_status = 8'h02;
      cyc(3);
      core_status = 8'h01;
      cyc(2);
      core_status = 8'h00;
    end
    wait_done("t3_done");
    cyc(3);
    chk("t3_n_start", n_start, 3);
    chk("t3_n_done", n_done, 1);
    chk("t3_viol", n_viol, 0);
    chk("t3_blk", blk_count, 3);

    // T4: 50 stall cycles, then stall timeout
    zero_cnt();
    accept(1'b0, 32'h2, 32'h4, 32'd4, 16'd1);
    chk("t4_stall_clr", stall_cnt, 0);
    wait_start("t4_start");
    core_status = 8'h02;
    cyc(2);
    core_status = 8'h06;
    cyc(50);
    core_status = 8'h02;
    cyc(1);
    chk("t4_stall50", stall_cnt, 50);
    chk("t4_no_err", n_err, 0);
    core_status = 8'h0A;
    k = 0;
    while (!run_err && k < 1100) begin
      cyc(1);
      k++;
    end
    chk("t4_to_cycles", k, 1024);
    chk("t4_code", err_code, 2);
    chk("t4_stall_tot", stall_cnt, 1074);
    chk("t4_blk", blk_count, 0);
    core_status = 8'h00;
    cyc(1);
    chk("t4_ready", rq_if.req_ready, 1);

    // T5: no acknowledge from the core
    zero_cnt();
    accept(1'b0, 32'h3, 32'h9, 32'd2, 16'd1);
    chk("t5_code_clr", err_code, 0);
    wait_start("t5_start");
    k = 0;
    while (!run_err && k < 1100) begin
      cyc(1);
      k++;
    end
    chk("t5_to_cycles", k, 1025);
    chk("t5_code", err_code, 1);
    cyc(1);
    chk("t5_ready", rq_if.req_ready, 1);

    // T6: abort coincident with done
    zero_cnt();
    accept(1'b0, 32'h5, 32'h19, 32'd3, 16'd2);
    wait_start("t6_start");
    core_status = 8'h02;
    cyc(2);
    core_status = 8'h01;
    abort = 1'b1;
    cyc(1);
    chk("t6_err", run_err, 1);
    chk("t6_code", err_code, 3);
    chk("t6_blk", blk_count, 0);
    abort = 1'b0;
    core_status = 8'h00;
    cyc(1);
    chk("t6_ready", rq_if.req_ready, 1);

    // abort during START masks the pulse
    accept(1'b0, 32'h6, 32'h24, 32'd3, 16'd1);
    cyc(1);
    abort = 1'b1;
    #1;
    chk("t6_start_masked", core_start, 0);
    cyc(1);
    chk("t6_abort_err", run_err, 1);
    chk("t6_abort_code", err_code, 3);
    cyc(1);

    // nblk=0 accepted while abort held in IDLE
    zero_cnt();
    accept(1'b0, 32'h7, 32'h31, 32'd1, 16'd0);
    chk("t6_nblk0_done", run_done, 1);
    chk("t6_nblk0_code", err_code, 0);
    cyc(3);
    abort = 1'b0;
    chk("t6_nblk0_nstart", n_start, 0);
    chk("t6_nblk0_nerr", n_err, 0);

    // async reset mid-run
    accept(1'b0, 32'h8, 32'h40, 32'd5, 16'd1);
    cyc(1);
    chk("mid_start", core_start, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_start", core_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cfg", core_config_reg, 0);
    #10;
    rstn = 1'b1;
    cyc(2);
    chk("mid_rst_ready", rq_if.req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
